// File: rtl/stopwatch_pkg.sv
//============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch datapath.
//               Holds the default BCD digit count and binary width used by
//               the BCD-to-binary converter, the BCD digit type, the
//               converter state encoding and a digit validity helper.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package stopwatch_pkg;

    // Default converter geometry: four BCD digits (0..9999) need 14 bits.
    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 14;

    typedef logic [3:0] bcd_digit_t;

    // Converter states. There is no separate DONE state: the last shift
    // returns straight to IDLE while raising done.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } b2_state_t;

    // A BCD digit is invalid when it encodes 10..15.
    function automatic logic digit_invalid(input bcd_digit_t d);
        return (d > 4'd9);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_if.sv
//============================================================================
// Module      : bcd_to_binary_if
// Description : Request/result bundle of the BCD-to-binary converter.
//               master : requester (drives start/bcd, observes results)
//               slave  : converter (observes start/bcd, drives results)
// Signals     : start  - request conversion (taken only while ready=1)
//               bcd    - packed BCD, digit 0 in [3:0]
//               ready  - converter idle, can accept start
//               done   - one-cycle pulse, bin/err valid
//               bin    - converted value, held until the next done
//               err    - invalid-digit flag, qualified by done
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface bcd_to_binary_if #(
    parameter int DIGITS = stopwatch_pkg::BCD_DIGITS,
    parameter int BIN_W  = stopwatch_pkg::BIN_W
);

    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ready;
    logic                  done;
    logic [BIN_W-1:0]      bin;
    logic                  err;

    modport master (
        output start,
        output bcd,
        input  ready,
        input  done,
        input  bin,
        input  err
    );

    modport slave (
        input  start,
        input  bcd,
        output ready,
        output done,
        output bin,
        output err
    );

endinterface

`default_nettype wire

// File: rtl/bcd_digit_correct.sv
//============================================================================
// Module      : bcd_digit_correct
// Description : Reverse double-dabble digit correction. After a right shift
//               a BCD field holding 8 or more received a carried-in "10"
//               worth 8 instead of 5, so 3 is subtracted. Values below 8
//               pass unchanged. The subtract cannot underflow.
// Ports       : d_i - shifted 4-bit BCD field
//               d_o - corrected field
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module bcd_digit_correct
    import stopwatch_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    assign d_o = d_i[3] ? (d_i - 4'd3) : d_i;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary.sv
//============================================================================
// Module      : bcd_to_binary
// Description : Sequential BCD-to-binary converter (reverse double dabble).
//               A scratch register {bcd field, bin field} is shifted right
//               BIN_W times; after every shift each BCD field >= 8 has 3
//               subtracted. The bin field then holds the binary value.
//               Latency: done is high in the cycle after the BIN_W-th edge
//               following acceptance; ready rises together with done.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - bcd_to_binary_if.slave (start/bcd in,
//                       ready/done/bin/err out)
// Options     : BCD_CHECK_EN - when defined, digits > 9 on the accepted
//               input give err=1 and bin=0 at done; otherwise err is 0 and
//               invalid digits yield the raw algorithm result.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module bcd_to_binary
    import stopwatch_pkg::*;
#(
    parameter int DIGITS = BCD_DIGITS,
    parameter int BIN_W  = stopwatch_pkg::BIN_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_to_binary_if.slave     bus
);

    localparam int              SCR_W    = 4 * DIGITS + BIN_W;
    localparam int              CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    b2_state_t          state_q, state_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]   shifted;
    wire  [SCR_W-1:0]   corrected;
    logic [BIN_W-1:0]   result;
    logic               accept;
    logic               last_shift;

    //------------------------------------------------------------------------
    // Shift + per-digit correction datapath. All BCD fields are corrected in
    // parallel; the bin field just receives the shifted-out bits.
    //------------------------------------------------------------------------
    assign shifted = scratch_q >> 1;
    assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_correct u_correct (
                .d_i (shifted[BIN_W + 4*g +: 4]),
                .d_o (corrected[BIN_W + 4*g +: 4])
            );
        end
    endgenerate

    assign accept     = (state_q == IDLE) && bus.start;
    assign last_shift = (cnt_q == LAST_CNT);

`ifdef BCD_CHECK_EN
    //------------------------------------------------------------------------
    // Invalid-digit check: captured on acceptance, applied at done.
    //------------------------------------------------------------------------
    logic invalid_q, invalid_d;
    logic err_q, err_d;
    logic any_bad;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_invalid(bus.bcd[4*i +: 4])) begin
                any_bad = 1'b1;
            end
        end
        invalid_d = accept ? any_bad : invalid_q;
        err_d     = done_d ? invalid_q : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
            err_q     <= err_d;
        end
    end

    assign result  = invalid_q ? '0 : corrected[BIN_W-1:0];
    assign bus.err = err_q;
`else
    assign result  = corrected[BIN_W-1:0];
    assign bus.err = 1'b0;
`endif

    //------------------------------------------------------------------------
    // Next-state / output logic
    //------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scratch_d = {bus.bcd, {BIN_W{1'b0}}};
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = corrected;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_shift) begin
                    bin_d   = result;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            bin_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.done  = done_q;
    assign bus.bin   = bin_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_binary.sv
//============================================================================
// Module      : tb_bcd_to_binary
// Description : Self-checking bench for bcd_to_binary. Expected results come
//               from the decimal value of the BCD word (sum of digit*10^i).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_bcd_to_binary;

    localparam int ND = 4;
    localparam int BW = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bcd_to_binary_if #(.DIGITS(ND), .BIN_W(BW)) bus ();

    bcd_to_binary #(.DIGITS(ND), .BIN_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dec_value(input logic [4*ND-1:0] v);
        int acc = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            acc = acc * 10 + int'(v[4*i +: 4]);
        end
        return acc;
    endfunction

    function automatic bit has_bad_digit(input logic [4*ND-1:0] v);
        bit b = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // Issue one request, count edges after the accepting edge until done.
    task automatic convert(input logic [4*ND-1:0] v, output logic [BW-1:0] b,
                           output logic e, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ready_low_after_accept", {31'd0, bus.ready}, 32'd0);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        b = bus.bin;
        e = bus.err;
    endtask

    task automatic run_one(input logic [4*ND-1:0] v);
        logic [BW-1:0] b;
        logic          e;
        int            lat;
        convert(v, b, e, lat);
        check($sformatf("latency_%h", v), lat, BW);
        if (has_bad_digit(v)) begin
`ifdef BCD_CHECK_EN
            check($sformatf("bin_%h", v), {18'd0, b}, 32'd0);
            check($sformatf("err_%h", v), {31'd0, e}, 32'd1);
`else
            check($sformatf("err_%h", v), {31'd0, e}, 32'd0);
`endif
        end else begin
            check($sformatf("bin_%h", v), {18'd0, b}, dec_value(v));
            check($sformatf("err_%h", v), {31'd0, e}, 32'd0);
        end
        check($sformatf("ready_in_done_%h", v), {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("done_one_cycle_%h", v), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [4*ND-1:0] v;
        logic [BW-1:0]   b;
        logic            e;
        int              lat;
        int              dones;

        bus.start = 1'b0;
        bus.bcd   = '0;

        // Reset: asynchronous assertion, then release
        #3 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        check("rst_bin",   {18'd0, bus.bin},   32'd0);
        check("rst_err",   {31'd0, bus.err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'd0, bus.ready}, 32'd1);
        check("post_rst_done",  {31'd0, bus.done},  32'd0);
        check("post_rst_bin",   {18'd0, bus.bin},   32'd0);

        // Directed values including boundaries
        run_one(16'h1234);
        run_one(16'h9999);
        run_one(16'h0000);
        run_one(16'h0001);
        run_one(16'h1000);
        run_one(16'h0999);
        run_one(16'h8080);

        // Random valid BCD values
        for (int k = 0; k < 300; k++) begin
            for (int d = 0; d < ND; d++) begin
                v[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            run_one(v);
        end

        // Back-to-back: start held high; the second request is taken on the
        // edge that ends the first done cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h0059;
        @(posedge clk);
        #1;
        bus.bcd = 16'h3600;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat1", lat, BW);
        check("b2b_bin1", {18'd0, bus.bin}, 32'd59);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_done_gap",  {31'd0, bus.done},  32'd0);
        check("b2b_reaccept",  {31'd0, bus.ready}, 32'd0);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat2", lat, BW);
        check("b2b_bin2", {18'd0, bus.bin}, 32'd3600);
        @(posedge clk);
        #1;

        // start while busy is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h1234;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (lat == 5) begin
                bus.start = 1'b1;
                bus.bcd   = 16'h9999;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        check("busy_lat", lat, BW);
        check("busy_bin", {18'd0, bus.bin}, 32'd1234);
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("busy_not_queued", dones, 0);
        check("busy_idle_ready", {31'd0, bus.ready}, 32'd1);

        // Reset mid-conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd   = 16'h4321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, bus.ready}, 32'd1);
        check("abort_done",  {31'd0, bus.done},  32'd0);
        check("abort_bin",   {18'd0, bus.bin},   32'd0);
        check("abort_err",   {31'd0, bus.err},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_ready_after", {31'd0, bus.ready}, 32'd1);

        // Invalid digit input
        run_one(16'h12A4);
        convert(16'h12A4, b, e, lat);
`ifdef BCD_CHECK_EN
        check("invalid_err", {31'd0, e}, 32'd1);
        check("invalid_bin", {18'd0, b}, 32'd0);
`else
        check("invalid_err", {31'd0, e}, 32'd0);
`endif
        // A valid conversion right after an invalid one must clear err.
        run_one(16'h0042);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
